// File: rtl/rob_commit_if.sv
// Issue, writeback, operand-lookup and commit signals of the reorder buffer.
// The issue/execute side uses the master modport; the ROB uses the slave modport.
interface rob_commit_if #(
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3,
   parameter int DATA_W = 16,
   parameter int REG_W  = 4
);
   logic              flush;
   logic              alloc_v;
   logic [REG_W-1:0]  alloc_rd;
   logic              alloc_rdy;
   logic [IDX_W-1:0]  alloc_idx;
   logic              wb_v;
   logic [IDX_W-1:0]  wb_idx;
   logic [DATA_W-1:0] wb_data;
   logic [IDX_W-1:0]  src_idx;
   logic              src_done;
   logic [DATA_W-1:0] src_data;
   logic              commit_v;
   logic [IDX_W-1:0]  commit_idx;
   logic [REG_W-1:0]  commit_rd;
   logic [DATA_W-1:0] commit_data;
   logic [IDX_W:0]    count;
   logic              full;
   logic              empty;
   logic              wb_err;

   modport master (
      output flush, alloc_v, alloc_rd, wb_v, wb_idx, wb_data, src_idx,
      input  alloc_rdy, alloc_idx, src_done, src_data,
      input  commit_v, commit_idx, commit_rd, commit_data,
      input  count, full, empty, wb_err
   );

   modport slave (
      input  flush, alloc_v, alloc_rd, wb_v, wb_idx, wb_data, src_idx,
      output alloc_rdy, alloc_idx, src_done, src_data,
      output commit_v, commit_idx, commit_rd, commit_data,
      output count, full, empty, wb_err
   );
endinterface

// File: rtl/rob_commit.sv
// Eight-entry reorder buffer: allocates at tail, accepts out-of-order writeback,
// retires done entries in program order one per cycle, and serves operand lookups.
module rob_commit #(
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3,
   parameter int DATA_W = 16,
   parameter int REG_W  = 4
) (
   input logic         clk1,
   input logic         rst,
   rob_commit_if.slave bus
);

   localparam int CNT_W = IDX_W + 1;

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  done_q, done_d;
   logic [REG_W-1:0]  rd_q    [DEPTH];
   logic [REG_W-1:0]  rd_d    [DEPTH];
   logic [DATA_W-1:0] value_q [DEPTH];
   logic [DATA_W-1:0] value_d [DEPTH];

   logic [IDX_W-1:0]  head_q, head_d;
   logic [IDX_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wb_err_q, wb_err_d;

   logic              commit_v_q, commit_v_d;
   logic [IDX_W-1:0]  commit_idx_q, commit_idx_d;
   logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
   logic [DATA_W-1:0] commit_data_q, commit_data_d;

   logic full_w;
   logic alloc_ok;
   logic commit_ok;
   logic wb_ok;
   logic src_done_w;

   // Status is taken from registered state only, so a commit never frees a slot
   // for an allocation in the same cycle.
   assign full_w     = (count_q == CNT_W'(DEPTH));
   assign alloc_ok   = bus.alloc_v & ~full_w;
   assign commit_ok  = valid_q[head_q] & done_q[head_q];
   assign wb_ok      = valid_q[bus.wb_idx] & ~done_q[bus.wb_idx];
   assign src_done_w = valid_q[bus.src_idx] & done_q[bus.src_idx];

   always_comb begin
      valid_d       = valid_q;
      done_d        = done_q;
      rd_d          = rd_q;
      value_d       = value_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      wb_err_d      = wb_err_q;
      commit_v_d    = 1'b0;
      commit_idx_d  = commit_idx_q;
      commit_rd_d   = commit_rd_q;
      commit_data_d = commit_data_q;

      if (bus.flush) begin
         valid_d = '0;
         done_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // An entry allocated this cycle is still invalid here, so a writeback
         // aimed at it is flagged as an error.
         if (bus.wb_v) begin
            if (wb_ok) begin
               done_d[bus.wb_idx]  = 1'b1;
               value_d[bus.wb_idx] = bus.wb_data;
            end else begin
               wb_err_d = 1'b1;
            end
         end

         if (commit_ok) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + IDX_W'(1);
            commit_v_d      = 1'b1;
            commit_idx_d    = head_q;
            commit_rd_d     = rd_q[head_q];
            commit_data_d   = value_q[head_q];
         end

         if (alloc_ok) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            rd_d[tail_q]    = bus.alloc_rd;
            value_d[tail_q] = '0;
            tail_d          = tail_q + IDX_W'(1);
         end

         count_d = count_q + CNT_W'(alloc_ok) - CNT_W'(commit_ok);
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         valid_q       <= '0;
         done_q        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]    <= '0;
            value_q[i] <= '0;
         end
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         wb_err_q      <= 1'b0;
         commit_v_q    <= 1'b0;
         commit_idx_q  <= '0;
         commit_rd_q   <= '0;
         commit_data_q <= '0;
      end else begin
         valid_q       <= valid_d;
         done_q        <= done_d;
         rd_q          <= rd_d;
         value_q       <= value_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         wb_err_q      <= wb_err_d;
         commit_v_q    <= commit_v_d;
         commit_idx_q  <= commit_idx_d;
         commit_rd_q   <= commit_rd_d;
         commit_data_q <= commit_data_d;
      end
   end

   assign bus.alloc_rdy   = ~full_w;
   assign bus.alloc_idx   = tail_q;
   assign bus.src_done    = src_done_w;
   assign bus.src_data    = src_done_w ? value_q[bus.src_idx] : '0;
   assign bus.commit_v    = commit_v_q;
   assign bus.commit_idx  = commit_idx_q;
   assign bus.commit_rd   = commit_rd_q;
   assign bus.commit_data = commit_data_q;
   assign bus.count       = count_q;
   assign bus.full        = full_w;
   assign bus.empty       = (count_q == '0);
   assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios plus a randomized run, all checked
// against a program-order queue model of the reorder buffer.
module tb_rob_commit;
   localparam int DEPTH  = 8;
   localparam int IDX_W  = 3;
   localparam int DATA_W = 16;
   localparam int REG_W  = 4;
   localparam int CNT_W  = IDX_W + 1;

   logic clk1 = 1'b0;
   logic rst  = 1'b1;
   always #5 clk1 = ~clk1;

   rob_commit_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

   rob_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model: in-flight instructions in program order, oldest first.
   typedef struct {
      int idx;
      int rd;
      bit done;
      int val;
   } ent_t;

   ent_t mq[$];
   int   m_tail;
   bit   m_err;
   bit   m_cv;
   int   m_cidx, m_crd, m_cdata;

   function automatic void model_edge();
      bit take;
      bit was_full;
      bit found;
      if (rst) begin
         mq.delete();
         m_tail = 0; m_err = 0; m_cv = 0; m_cidx = 0; m_crd = 0; m_cdata = 0;
         return;
      end
      if (bus.flush) begin
         mq.delete();
         m_tail = 0; m_cv = 0;
         return;
      end
      take     = (mq.size() > 0) && mq[0].done;
      was_full = (mq.size() == DEPTH);
      if (take) begin
         m_cv = 1; m_cidx = mq[0].idx; m_crd = mq[0].rd; m_cdata = mq[0].val;
      end else begin
         m_cv = 0;
      end
      if (bus.wb_v) begin
         found = 0;
         foreach (mq[k]) begin
            if (mq[k].idx == int'(bus.wb_idx)) begin
               found = 1;
               if (mq[k].done) m_err = 1;
               else begin
                  mq[k].done = 1;
                  mq[k].val  = int'(bus.wb_data);
               end
            end
         end
         if (!found) m_err = 1;
      end
      if (take) void'(mq.pop_front());
      if (bus.alloc_v && !was_full) begin
         mq.push_back('{idx: m_tail, rd: int'(bus.alloc_rd), done: 1'b0, val: 0});
         m_tail = (m_tail + 1) % DEPTH;
      end
   endfunction

   function automatic bit m_src_done(int i);
      foreach (mq[k]) if (mq[k].idx == i) return mq[k].done;
      return 1'b0;
   endfunction

   function automatic int m_src_data(int i);
      foreach (mq[k]) if (mq[k].idx == i && mq[k].done) return mq[k].val;
      return 0;
   endfunction

   task automatic idle();
      bus.flush = 0; bus.alloc_v = 0; bus.alloc_rd = '0;
      bus.wb_v = 0; bus.wb_idx = '0; bus.wb_data = '0; bus.src_idx = '0;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk1);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      bus.alloc_v = 1; bus.alloc_rd = 4'd9;
      tick();
      rst = 0;
      idle();
      #1;
      checks++; if (bus.commit_v !== 1'b0) begin failures++; $display("FAIL reset_commit_v got=%0d exp=0", bus.commit_v); end
      checks++; if (bus.commit_idx !== '0 || bus.commit_rd !== '0 || bus.commit_data !== '0) begin failures++; $display("FAIL reset_commit_fields got=%0d/%0d/%0h exp=0/0/0", bus.commit_idx, bus.commit_rd, bus.commit_data); end
      checks++; if (bus.count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      checks++; if (bus.full !== 1'b0 || bus.empty !== 1'b1 || bus.alloc_rdy !== 1'b1) begin failures++; $display("FAIL reset_flags full=%0d empty=%0d rdy=%0d exp=0/1/1", bus.full, bus.empty, bus.alloc_rdy); end
      checks++; if (bus.alloc_idx !== '0) begin failures++; $display("FAIL reset_alloc_idx got=%0d exp=0", bus.alloc_idx); end
      checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL reset_wb_err got=%0d exp=0", bus.wb_err); end
      checks++; if (bus.src_done !== 1'b0 || bus.src_data !== '0) begin failures++; $display("FAIL reset_src got=%0d/%0h exp=0/0", bus.src_done, bus.src_data); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         bus.alloc_v = 1; bus.alloc_rd = REG_W'(i + 1);
         #1;
         checks++; if (bus.alloc_idx !== IDX_W'(i)) begin failures++; $display("FAIL fill_alloc_idx got=%0d exp=%0d", bus.alloc_idx, i); end
         tick();
      end
      checks++; if (bus.count !== CNT_W'(8) || bus.full !== 1'b1 || bus.alloc_rdy !== 1'b0) begin failures++; $display("FAIL fill_full count=%0d full=%0d rdy=%0d exp=8/1/0", bus.count, bus.full, bus.alloc_rdy); end
      bus.alloc_v = 1; bus.alloc_rd = 4'd15;
      tick();
      idle();
      #1;
      checks++; if (bus.alloc_idx !== '0 || bus.count !== CNT_W'(8) || bus.alloc_rdy !== 1'b0) begin failures++; $display("FAIL fill_ninth idx=%0d count=%0d rdy=%0d exp=0/8/0", bus.alloc_idx, bus.count, bus.alloc_rdy); end
   endtask

   task automatic test_ooo_wb();
      int exp_data [3] = '{16'h0010, 16'h0020, 16'h0030};
      int exp_rd   [3] = '{5, 6, 7};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         bus.alloc_v = 1; bus.alloc_rd = REG_W'(exp_rd[i]);
         tick();
      end
      idle();
      for (int i = 2; i >= 0; i--) begin
         bus.wb_v = 1; bus.wb_idx = IDX_W'(i); bus.wb_data = DATA_W'(exp_data[i]);
         tick();
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.commit_v !== 1'b1 || bus.commit_idx !== IDX_W'(i) || bus.commit_rd !== REG_W'(exp_rd[i]) || bus.commit_data !== DATA_W'(exp_data[i])) begin
            failures++;
            $display("FAIL ooo_commit%0d got v=%0d idx=%0d rd=%0d data=%0h exp v=1 idx=%0d rd=%0d data=%0h",
                     i, bus.commit_v, bus.commit_idx, bus.commit_rd, bus.commit_data, i, exp_rd[i], exp_data[i]);
         end
      end
      tick();
      checks++; if (bus.commit_v !== 1'b0 || bus.empty !== 1'b1 || bus.commit_data !== 16'h0030) begin failures++; $display("FAIL ooo_after v=%0d empty=%0d data=%0h exp 0/1/30", bus.commit_v, bus.empty, bus.commit_data); end
   endtask

   task automatic test_full_simul();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         bus.alloc_v = 1; bus.alloc_rd = REG_W'(i);
         tick();
      end
      idle();
      bus.wb_v = 1; bus.wb_idx = '0; bus.wb_data = 16'h0055;
      tick();
      idle();
      bus.alloc_v = 1; bus.alloc_rd = 4'd9;
      #1;
      checks++; if (bus.alloc_rdy !== 1'b0) begin failures++; $display("FAIL simul_rdy got=%0d exp=0", bus.alloc_rdy); end
      tick();
      checks++; if (bus.commit_v !== 1'b1 || bus.commit_idx !== '0 || bus.commit_data !== 16'h0055) begin failures++; $display("FAIL simul_commit v=%0d idx=%0d data=%0h exp 1/0/55", bus.commit_v, bus.commit_idx, bus.commit_data); end
      checks++; if (bus.count !== CNT_W'(7) || bus.alloc_idx !== '0) begin failures++; $display("FAIL simul_count count=%0d idx=%0d exp 7/0", bus.count, bus.alloc_idx); end
      tick();
      checks++; if (bus.count !== CNT_W'(8) || bus.full !== 1'b1 || bus.alloc_idx !== IDX_W'(1)) begin failures++; $display("FAIL simul_refill count=%0d full=%0d tail=%0d exp 8/1/1", bus.count, bus.full, bus.alloc_idx); end
      idle();
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         bus.alloc_v = 1; bus.alloc_rd = REG_W'(i);
         tick();
         idle();
         bus.wb_v = 1; bus.wb_idx = IDX_W'(i % DEPTH); bus.wb_data = DATA_W'(16'h0100 + i);
         tick();
         idle();
         tick();
         checks++;
         if (bus.commit_v !== 1'b1 || bus.commit_idx !== IDX_W'(i % DEPTH) || bus.commit_data !== DATA_W'(16'h0100 + i) || bus.count !== '0 || bus.wb_err !== 1'b0) begin
            failures++;
            $display("FAIL wrap%0d v=%0d idx=%0d data=%0h count=%0d err=%0d exp 1/%0d/%0h/0/0",
                     i, bus.commit_v, bus.commit_idx, bus.commit_data, bus.count, bus.wb_err, i % DEPTH, 16'h0100 + i);
         end
      end
   endtask

   task automatic test_err_lookup();
      do_reset();
      bus.wb_v = 1; bus.wb_idx = 3'd5; bus.wb_data = 16'h1234;
      tick();
      idle();
      checks++; if (bus.wb_err !== 1'b1) begin failures++; $display("FAIL err_unalloc got=%0d exp=1", bus.wb_err); end
      bus.alloc_v = 1; bus.alloc_rd = 4'd2;
      tick();
      tick();
      idle();
      bus.wb_v = 1; bus.wb_idx = '0; bus.wb_data = 16'h00AB;
      tick();
      idle();
      bus.src_idx = '0;
      #1;
      checks++; if (bus.src_done !== 1'b1 || bus.src_data !== 16'h00AB) begin failures++; $display("FAIL lookup_done got=%0d/%0h exp 1/ab", bus.src_done, bus.src_data); end
      bus.src_idx = 3'd1;
      #1;
      checks++; if (bus.src_done !== 1'b0 || bus.src_data !== '0) begin failures++; $display("FAIL lookup_pending got=%0d/%0h exp 0/0", bus.src_done, bus.src_data); end
      tick();
      tick();
      checks++; if (bus.wb_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0d exp=1", bus.wb_err); end
      do_reset();
      bus.alloc_v = 1; bus.alloc_rd = 4'd3;
      bus.wb_v = 1; bus.wb_idx = '0; bus.wb_data = 16'h0077;
      tick();
      idle();
      checks++; if (bus.wb_err !== 1'b1 || bus.count !== CNT_W'(1)) begin failures++; $display("FAIL err_same_cycle err=%0d count=%0d exp 1/1", bus.wb_err, bus.count); end
   endtask

   task automatic test_flush();
      do_reset();
      bus.wb_v = 1; bus.wb_idx = 3'd6;
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         bus.alloc_v = 1; bus.alloc_rd = REG_W'(i + 10);
         tick();
      end
      idle();
      bus.wb_v = 1; bus.wb_idx = 3'd1; bus.wb_data = 16'h0011;
      tick();
      bus.wb_idx = 3'd3; bus.wb_data = 16'h0033;
      tick();
      idle();
      bus.flush = 1;
      tick();
      idle();
      bus.src_idx = 3'd1;
      #1;
      checks++; if (bus.count !== '0 || bus.empty !== 1'b1 || bus.commit_v !== 1'b0 || bus.alloc_idx !== '0) begin failures++; $display("FAIL flush_state count=%0d empty=%0d v=%0d tail=%0d exp 0/1/0/0", bus.count, bus.empty, bus.commit_v, bus.alloc_idx); end
      checks++; if (bus.wb_err !== 1'b1 || bus.src_done !== 1'b0) begin failures++; $display("FAIL flush_keep err=%0d src_done=%0d exp 1/0", bus.wb_err, bus.src_done); end
      rst = 1;
      bus.alloc_v = 1; bus.alloc_rd = 4'd4;
      tick();
      rst = 0;
      idle();
      #1;
      checks++; if (bus.count !== '0 || bus.alloc_idx !== '0 || bus.wb_err !== 1'b0 || bus.commit_v !== 1'b0 || bus.empty !== 1'b1) begin failures++; $display("FAIL rst_alloc count=%0d tail=%0d err=%0d v=%0d empty=%0d exp 0/0/0/0/1", bus.count, bus.alloc_idx, bus.wb_err, bus.commit_v, bus.empty); end
   endtask

   task automatic test_random();
      int pend[$];
      int src;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         idle();
         bus.flush    = ($urandom_range(0, 99) < 2);
         bus.alloc_v  = ($urandom_range(0, 99) < 55);
         bus.alloc_rd = REG_W'($urandom);
         pend.delete();
         foreach (mq[k]) if (!mq[k].done) pend.push_back(mq[k].idx);
         if ($urandom_range(0, 99) < 60) begin
            bus.wb_v = 1;
            if (pend.size() > 0 && $urandom_range(0, 99) < 85)
               bus.wb_idx = IDX_W'(pend[$urandom_range(0, pend.size() - 1)]);
            else
               bus.wb_idx = IDX_W'($urandom);
            bus.wb_data = DATA_W'($urandom);
         end
         src = int'($urandom_range(0, DEPTH - 1));
         bus.src_idx = IDX_W'(src);
         #1;
         checks++;
         if (bus.count !== CNT_W'(mq.size()) || bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0) ||
             bus.alloc_rdy !== (mq.size() != DEPTH) || bus.alloc_idx !== IDX_W'(m_tail)) begin
            failures++;
            $display("FAIL rand_status cyc=%0d count=%0d full=%0d empty=%0d rdy=%0d tail=%0d exp count=%0d tail=%0d",
                     cyc, bus.count, bus.full, bus.empty, bus.alloc_rdy, bus.alloc_idx, mq.size(), m_tail);
         end
         checks++;
         if (bus.src_done !== m_src_done(src) || bus.src_data !== DATA_W'(m_src_data(src))) begin
            failures++;
            $display("FAIL rand_src cyc=%0d idx=%0d got=%0d/%0h exp=%0d/%0h", cyc, src, bus.src_done, bus.src_data, m_src_done(src), m_src_data(src));
         end
         tick();
         checks++;
         if (bus.commit_v !== m_cv || bus.commit_idx !== IDX_W'(m_cidx) || bus.commit_rd !== REG_W'(m_crd) ||
             bus.commit_data !== DATA_W'(m_cdata) || bus.wb_err !== m_err) begin
            failures++;
            $display("FAIL rand_commit cyc=%0d got v=%0d idx=%0d rd=%0d data=%0h err=%0d exp v=%0d idx=%0d rd=%0d data=%0h err=%0d",
                     cyc, bus.commit_v, bus.commit_idx, bus.commit_rd, bus.commit_data, bus.wb_err, m_cv, m_cidx, m_crd, m_cdata, m_err);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_fill();
      test_ooo_wb();
      test_full_simul();
      test_wrap();
      test_err_lookup();
      test_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
